// File: rtl/gate_chk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gate_chk_pkg
//  Description : Shared definitions for the gate response checker:
//                FSM state encoding, settle counter width and a helper
//                returning the number of input vectors for a given N_IN.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package gate_chk_pkg;

    // Width of the settle down-counter; SETTLE is limited to 1..15.
    localparam int unsigned SETTLE_W = 4;

    // Checker FSM states.
    typedef logic [1:0] gate_chk_state_t;
    localparam gate_chk_state_t c_ST_IDLE = 2'd0;
    localparam gate_chk_state_t c_ST_RUN  = 2'd1;
    localparam gate_chk_state_t c_ST_DONE = 2'd2;

    // Number of input vectors exercised in one run: 2^n_in.
    function automatic int unsigned num_vectors(input int unsigned n_in);
        return 32'd1 << n_in;
    endfunction

endpackage : gate_chk_pkg
`default_nettype wire

// File: rtl/gate_chk_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gate_chk_timer
//  Description : Reloadable settle down-counter. load has priority and sets
//                the count to load_val; while en is high the count decrements
//                towards zero and holds there. expire flags the edge on which
//                an enabled counter sits at zero.
//  Ports       : clk      - clock, rising edge
//                rst_n    - asynchronous active-low reset
//                load     - reload the counter with load_val
//                en       - count enable
//                load_val - reload value (SETTLE-1)
//                expire   - counter enabled and at zero
//  Revision    : 1.0  initial release
// ============================================================================
module gate_chk_timer
    import gate_chk_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                en,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expire
);

    logic [SETTLE_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expire = en && (r_count == '0);

endmodule : gate_chk_timer
`default_nettype wire

// File: rtl/gate_resp_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : gate_resp_checker
//  Description : Self-checking exerciser for small combinational gates.
//                Walks every input vector onto the DUT, holds each for
//                SETTLE cycles, samples dut_y on the last edge of the hold
//                and compares it with TRUTH. Reports the mismatch count, the
//                lowest failing vector and a pass flag.
//                Optional build macro GATE_CHK_STOP_ON_ERR_EN: when defined,
//                the first mismatch ends the run at that sample edge.
//  Parameters  : N_IN   - number of DUT inputs (1..4)
//                TRUTH  - expected output, bit i for input vector i
//                SETTLE - cycles each vector is held (1..15)
//  Ports       : clk           - clock, rising edge
//                rst_n         - asynchronous active-low reset
//                start         - run request, honoured only in IDLE
//                dut_y         - DUT output
//                dut_in        - registered vector driven to the DUT
//                busy          - run in progress
//                done          - one-cycle end-of-run pulse
//                pass          - run result, valid from done
//                err_cnt       - number of mismatching vectors
//                first_err_vld - a mismatch has been captured
//                first_err_vec - lowest-index failing vector
//  Revision    : 1.0  initial release
// ============================================================================
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = 4'b0001,
    parameter int                      SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_y,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic            first_err_vld,
    output logic [N_IN-1:0] first_err_vec
);

    localparam logic [N_IN-1:0]     c_LAST_VEC    = N_IN'(num_vectors(N_IN) - 1);
    localparam logic [SETTLE_W-1:0] c_SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    gate_chk_state_t  r_state;
    logic [N_IN-1:0]  r_dut_in;
    logic             r_busy;
    logic             r_pass;
    logic [N_IN:0]    r_err_cnt;
    logic             r_first_vld;
    logic [N_IN-1:0]  r_first_vec;

    logic             w_accept;
    logic             w_expire;
    logic             w_sample;
    logic             w_mismatch;
    logic             w_last;
    logic             w_finish;
    logic             w_timer_load;
    logic             w_timer_en;
    logic [N_IN:0]    w_err_next;

    assign w_accept   = (r_state == c_ST_IDLE) && start;
    assign w_timer_en = (r_state == c_ST_RUN);
    // The timer only expires while enabled, so an expiry is always a RUN sample edge.
    assign w_sample   = w_timer_en && w_expire;
    assign w_mismatch = w_sample && (dut_y != TRUTH[r_dut_in]);
    assign w_last     = (r_dut_in == c_LAST_VEC);
    // Count including the sample taken on this edge; pass is judged on it.
    assign w_err_next = r_err_cnt + {{N_IN{1'b0}}, w_mismatch};

`ifdef GATE_CHK_STOP_ON_ERR_EN
    assign w_finish   = w_sample && (w_last || w_mismatch);
`else
    assign w_finish   = w_sample && w_last;
`endif

    // Reload on run start and after every sample that does not end the run.
    assign w_timer_load = w_accept || (w_sample && !w_finish);

    gate_chk_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_timer_load),
        .en       (w_timer_en),
        .load_val (c_SETTLE_LOAD),
        .expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_dut_in    <= '0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_vec <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= c_ST_RUN;
                        r_busy      <= 1'b1;
                        r_dut_in    <= '0;
                        r_err_cnt   <= '0;
                        r_first_vld <= 1'b0;
                        r_first_vec <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                c_ST_RUN: begin
                    if (w_sample) begin
                        r_err_cnt <= w_err_next;
                        if (w_mismatch && !r_first_vld) begin
                            r_first_vld <= 1'b1;
                            r_first_vec <= r_dut_in;
                        end
                        if (w_finish) begin
                            r_state  <= c_ST_DONE;
                            r_busy   <= 1'b0;
                            r_dut_in <= '0;
                            r_pass   <= (w_err_next == '0);
                        end else begin
                            r_dut_in <= r_dut_in + 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    // start is deliberately ignored here; the next run can
                    // be accepted on the following edge from IDLE.
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign dut_in        = r_dut_in;
    assign busy          = r_busy;
    assign done          = (r_state == c_ST_DONE);
    assign pass          = r_pass;
    assign err_cnt       = r_err_cnt;
    assign first_err_vld = r_first_vld;
    assign first_err_vec = r_first_vec;

endmodule : gate_resp_checker
`default_nettype wire

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Synthesizable, self-checking exerciser for small combinational gates (NOR, NAND, XOR, etc.).
- Drives every input combination onto the device under test (DUT) and waits a settle interval before sampling the DUT output.
- Compares each sample against a parameterized truth table and reports the error count, the first failing vector and a pass/fail result.
- It is the checking end of the gate stimulus flow and lives beside the gate models, so one clocked block can verify any gate model.

Parameters:
- N_IN, 2, number of DUT inputs (1..4); 2^N_IN vectors per run.
- TRUTH, 4'b0001, width 2^N_IN; bit i is the expected y for input vector i. The default is NOR.
- SETTLE, 2, cycles each vector is held before sampling (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- dut_y  in  1  DUT output.
- dut_in  out  N_IN  registered vector driven to the DUT.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  valid from done; held until the next accepted start.
- err_cnt  out  N_IN+1  number of mismatching vectors.
- first_err_vld  out  1  at least one mismatch has been captured.
- first_err_vec  out  N_IN  lowest-index failing vector.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vld=0, first_err_vec=0, state=IDLE, settle counter=0.
- States: IDLE, RUN, DONE.
- IDLE: on an edge E0 with start=1, the block sets busy=1, dut_in=0, err_cnt=0, first_err_vld=0, first_err_vec=0 and pass=0. It loads the settle counter with SETTLE-1 and moves to RUN.
- RUN: the counter decrements each cycle. When it reaches 0, that edge is the sample edge, and dut_y is compared with TRUTH[dut_in].
  - On mismatch, err_cnt increments. If first_err_vld=0, the block captures first_err_vec=dut_in and sets first_err_vld=1.
  - If dut_in is not the last vector (2^N_IN-1), dut_in increments at the same edge and the counter reloads.
  - If dut_in is the last vector, the state moves to DONE, busy=0, dut_in=0, and pass=(final err_cnt==0), including the current sample.
- Timing:
  - Vector k is driven from edge E0+k*SETTLE and sampled at edge E0+(k+1)*SETTLE.
  - done is high in the cycle after edge E0+2^N_IN*SETTLE, i.e. 8 cycles after E0 for the defaults.
- DUT output between sample edges is never examined; glitches during settle are ignored.
- DONE: done=1 for exactly one cycle, then the state returns to IDLE. pass, err_cnt and first_err_* hold until the next accepted start.
- start while busy or in DONE is ignored.
- start in the cycle after DONE is accepted normally, giving back-to-back runs.
- Width rules:
  - err_cnt is at most 2^N_IN, so it fits N_IN+1 bits and needs no saturation.
  - The dut_in increment never wraps inside a run.
- Reset mid-run: the run aborts immediately, all outputs return to reset values and no done pulse is produced.

Optional Feature:
- GATE_CHK_STOP_ON_ERR_EN defined: the first mismatch ends the run at that sample edge.
  - The block goes to DONE with err_cnt=1, pass=0, first_err_* captured and dut_in=0.
  - Remaining vectors are skipped.
- Undefined: every vector is always checked, and err_cnt counts all mismatches.

Decomposition:
- Package gate_chk_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the settle counter width constant SETTLE_W=4;
  - the helper function computing 2^N_IN.
- Sub-module gate_chk_timer: the reloadable SETTLE down-counter, with inputs load/en and output expire. It is the only natural split; the FSM and scoreboard stay in gate_resp_checker.

Test Plan:
1. Correct NOR DUT, defaults: one start pulse -> dut_in=0,1,2,3 each for 2 cycles; done at E0+8; pass=1, err_cnt=0, first_err_vld=0.
2. AND DUT with the NOR truth table (actual y 0,0,0,1) -> mismatches at vectors 0 and 3; err_cnt=2, first_err_vec=0, pass=0.
3. Stuck-at-1 DUT -> err_cnt=3, first_err_vec=1, pass=0; a further start 1 cycle after done re-runs the check; err_cnt must read 0 in the cycle after the accepted start, then reach 3 again.
4. Correct NOR DUT with y forced wrong only in non-sample cycles -> pass=1, err_cnt=0. start held high for the whole run -> exactly one run, done pulse one cycle wide.
5. rst_n low for 1 cycle while dut_in=2 -> all outputs immediately return to reset values, no done pulse; the next start completes a clean run with pass=1.
6. With GATE_CHK_STOP_ON_ERR_EN defined, AND DUT -> done at E0+2, err_cnt=1, first_err_vec=0, pass=0, dut_in=0.
